mix_columns_sequencer: RTL and testbench
========================================

MIX_COLUMNS_SEQUENCER -- requirements
Module: mix_columns_sequencer

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Port list (name direction width meaning), clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  state_in is valid
- in_ready  out  1  block can accept a state
- state_in  in  128  input state; byte k = state_in[127-8k -: 8], column-major (byte 4c+r = row r, column c)
- out_valid  out  1  state_out is valid
- out_ready  in  1  consumer accepts state_out
- state_out  out  128  MixColumns result, same byte order
- row_index  out  2  row select driven to the fixed coefficient matrix ROM
- coef0..coef3  in  8 each  ROM row outputs (matrix row row_index, columns 0..3), combinational from row_index
- busy  out  1  high in CALC or DONE

Function
REQ-003 SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-004 IDLE: in_ready=1; on in_valid&&in_ready, SHALL capture state_in, clear the 4-bit step counter cnt and enter CALC.
REQ-005 CALC: cnt[3:2] = column c, cnt[1:0] = row r; row_index SHALL equal cnt[1:0] combinationally.
REQ-006 Each CALC cycle SHALL register result byte 4c+r = XOR over k=0..3 of gfmul(coef_k, captured byte 4c+k).
REQ-007 gfmul SHALL be full GF(2^8) multiply, reduction polynomial 0x11B, 8-bit result; any coefficient value is legal.
REQ-008 cnt SHALL increment by 1 each CALC cycle; when cnt=15 the FSM SHALL enter DONE on the next edge (16 CALC cycles, no wrap into a 17th step).
REQ-009 DONE: out_valid=1, state_out stable; on out_ready=1 SHALL return to IDLE on the next edge.
REQ-010 Latency: first valid out_valid 17 cycles after the accepting edge (16 CALC + DONE entry).
REQ-011 in_ready SHALL be 0 in CALC and DONE; in_valid there SHALL be ignored and state_in not sampled.
REQ-012 out_ready while not in DONE SHALL have no effect.
REQ-013 state_out SHALL hold the last completed result in IDLE; out_valid qualifies it.
REQ-014 Outside CALC, row_index SHALL be 2'b00.
REQ-015 The captured input state SHALL NOT change during CALC or DONE.

Reset
REQ-016 Asserting rst (low) SHALL, at any time including mid-CALC, force IDLE with cnt=0, captured state=0, state_out=0, out_valid=0, busy=0, in_ready=1 after release; no partial result SHALL be presented.
REQ-017 Reset deassertion SHALL be taken into account on the next rising clk edge; no handshake SHALL complete in the release cycle's preceding edge.

Structure
REQ-018 FSM state encoding, counter width (4) and reduction polynomial constant (0x11B) SHALL reside in a shared AES package.
REQ-019 The GF(2^8) multiplier SHALL be one combinational sub-module, gf_mul8 (a, b -> p), instantiated four times.
REQ-020 The coefficient ROM SHALL be external; the block contains no coefficient storage.

Verification (bench connects the standard MixColumns matrix 02 03 01 01 / 01 02 03 01 / 01 01 02 03 / 03 01 01 02 to coef0..3)
REQ-021 state_in columns db135345, f20a225c, 01010101, c6c6c6c6 -> state_out 8e4da1bc 9fdc589d 01010101 c6c6c6c6, out_valid exactly 17 cycles after accept.
REQ-022 FIPS-197 round-1 input d4bf5d30e0b452aeb84111f11e2798e5 -> 046681e5e0cb199a48f8d37a2806264c.
REQ-023 Hold out_ready=0 for 5 cycles in DONE -> out_valid and state_out stable, in_ready=0; raise out_ready -> IDLE next cycle, in_ready=1.
REQ-024 Pulse rst low at cnt=7 -> out_valid=0, state_out=0, in_ready=1 after release; new input then completes correctly.
REQ-025 Toggle in_valid with new data during CALC -> result matches originally captured state; row_index sequence 0,1,2,3 repeats four times.

Source files
------------

// File: rtl/mix_columns_sequencer_pkg.sv
// Shared AES definitions for the MixColumns sequencer.
//   state_e  : FSM encoding (IDLE / CALC / DONE)
//   CNT_W    : width of the byte-step counter (16 steps per state)
//   GF_POLY  : GF(2^8) reduction polynomial x^8+x^4+x^3+x+1
package mix_columns_sequencer_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int         CNT_W   = 4;
    localparam logic [8:0] GF_POLY = 9'h11B;
endpackage

// File: rtl/mix_columns_sequencer_if.sv
// Streaming handshake bundle for the MixColumns sequencer.
//   in_valid/in_ready/state_in    : input state, 128b column-major
//   out_valid/out_ready/state_out : result state, same byte order
// master = producer/consumer side (testbench), slave = the sequencer.
interface mix_columns_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out
    );
    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out
    );
endinterface

// File: rtl/mix_columns_sequencer_gf_mul8.sv
// gf_mul8: combinational GF(2^8) multiply, p = a * b mod GF_POLY.
//   a, b : 8-bit operands (any value)
//   p    : 8-bit product
// Shift-and-add: a is repeatedly multiplied by x (xtime) and accumulated
// into the product for every set bit of b.
module gf_mul8
    import mix_columns_sequencer_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);
    logic [7:0] acc;
    logic [7:0] sh;

    always_comb begin
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY[7:0] : 8'h00);
        end
        p = acc;
    end
endmodule

// File: rtl/mix_columns_sequencer.sv
// mix_columns_sequencer: computes AES MixColumns one result byte per cycle
// against an external coefficient ROM.
//   clk, rst          : clock, asynchronous active-low reset
//   bus (slave)       : input/output valid-ready handshake + 128b states
//   row_index         : ROM row select (cnt[1:0] in CALC, else 0)
//   coef0..coef3      : ROM row contents for row_index
//   busy              : high in CALC or DONE
// Byte k of a state sits at [127-8k -: 8]; byte 4c+r is row r, column c.
// The step counter walks byte 4c+r in order; each step combines the four
// bytes of column c with the ROM row r through four GF multipliers.
module mix_columns_sequencer
    import mix_columns_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    mix_columns_sequencer_if.slave bus,
    output logic [1:0]            row_index,
    input  logic [7:0]            coef0,
    input  logic [7:0]            coef1,
    input  logic [7:0]            coef2,
    input  logic [7:0]            coef3,
    output logic                  busy
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       din_q [16];
    logic [7:0]       res_q [16];
    logic [7:0]       coef  [4];
    logic [7:0]       prod  [4];
    logic [7:0]       mix_byte;

    assign coef[0] = coef0;
    assign coef[1] = coef1;
    assign coef[2] = coef2;
    assign coef[3] = coef3;

    // One multiplier per matrix column; operand is byte 4c+k of the
    // captured state, c taken from the upper counter bits.
    for (genvar k = 0; k < 4; k++) begin : g_mul
        localparam logic [1:0] KK = k;
        gf_mul8 u_mul (
            .a (coef[k]),
            .b (din_q[{cnt_q[3:2], KK}]),
            .p (prod[k])
        );
    end

    assign mix_byte = prod[0] ^ prod[1] ^ prod[2] ^ prod[3];

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid)       state_d = ST_CALC;
            ST_CALC: if (cnt_q == 4'hF)      state_d = ST_DONE;
            ST_DONE: if (bus.out_ready)      state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        busy          = (state_q != ST_IDLE);
        row_index     = (state_q == ST_CALC) ? cnt_q[1:0] : 2'b00;
        for (int k = 0; k < 16; k++) begin
            bus.state_out[127-8*k -: 8] = res_q[k];
        end
    end

    // Datapath. The input state is only written on an IDLE handshake, so it
    // stays frozen through CALC and DONE. Results land directly in res_q;
    // a reset mid-CALC clears it so no partial result survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            for (int k = 0; k < 16; k++) begin
                din_q[k] <= 8'h00;
                res_q[k] <= 8'h00;
            end
        end else if (state_q == ST_IDLE && bus.in_valid) begin
            cnt_q <= '0;
            for (int k = 0; k < 16; k++) begin
                din_q[k] <= bus.state_in[127-8*k -: 8];
            end
        end else if (state_q == ST_CALC) begin
            cnt_q        <= cnt_q + 1'b1;
            res_q[cnt_q] <= mix_byte;
        end
    end
endmodule

// File: tb/tb_mix_columns_sequencer.sv
// Directed bench for mix_columns_sequencer. The coefficient ROM is modelled
// here; inv selects the forward (02 03 01 01) or inverse (0e 0b 0d 09)
// MixColumns matrix, both circulant.
module tb_mix_columns_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] row_index;
    logic [7:0] coef0, coef1, coef2, coef3;
    logic       busy;
    logic       inv;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] V1_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] V2_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

    mix_columns_sequencer_if bus();

    mix_columns_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .row_index (row_index),
        .coef0     (coef0),
        .coef1     (coef1),
        .coef2     (coef2),
        .coef3     (coef3),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic inv_m, input int d);
        case (d)
            0:       return inv_m ? 8'h0e : 8'h02;
            1:       return inv_m ? 8'h0b : 8'h03;
            2:       return inv_m ? 8'h0d : 8'h01;
            default: return inv_m ? 8'h09 : 8'h01;
        endcase
    endfunction

    always_comb begin
        coef0 = rom(inv, (4 - int'(row_index)) % 4);
        coef1 = rom(inv, (5 - int'(row_index)) % 4);
        coef2 = rom(inv, (6 - int'(row_index)) % 4);
        coef3 = rom(inv, (7 - int'(row_index)) % 4);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept din on the next edge and wait (bounded) for out_valid;
    // the accepting edge counts as cycle 1.
    task automatic accept_and_wait(input string tag, input logic [127:0] din,
                                   input logic [127:0] exp);
        int n;
        bus.state_in = din;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.state_in = '0;
        check({tag, "_busy"}, 128'(busy), 128'(1));
        check({tag, "_in_ready_calc"}, 128'(bus.in_ready), 128'(0));
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'(17));
        check({tag, "_result"}, bus.state_out, exp);
    endtask

    task automatic release_out(input string tag, input logic [127:0] exp);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_in_ready_idle"}, 128'(bus.in_ready), 128'(1));
        check({tag, "_out_valid_idle"}, 128'(bus.out_valid), 128'(0));
        check({tag, "_held_result"}, bus.state_out, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        inv           = 1'b0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.state_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_state_out", bus.state_out, 128'(0));
        check("rst_row_index", 128'(row_index), 128'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // Forward matrix, textbook columns and FIPS-197 round 1
        accept_and_wait("v1", V1_IN, V1_OUT);
        release_out("v1", V1_OUT);
        accept_and_wait("fips", V2_IN, V2_OUT);
        release_out("fips", V2_OUT);

        // Inverse matrix exercises large coefficients; must undo the above
        inv = 1'b1;
        accept_and_wait("inv_v1", V1_OUT, V1_IN);
        release_out("inv_v1", V1_IN);
        accept_and_wait("inv_fips", V2_OUT, V2_IN);
        release_out("inv_fips", V2_IN);
        inv = 1'b0;

        // Backpressure in DONE, with in_valid noise that must be ignored
        accept_and_wait("hold", V1_IN, V1_OUT);
        bus.in_valid = 1'b1;
        bus.state_in = V2_IN;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", 128'(bus.out_valid), 128'(1));
            check("hold_state_out", bus.state_out, V1_OUT);
            check("hold_in_ready", 128'(bus.in_ready), 128'(0));
        end
        bus.in_valid = 1'b0;
        release_out("hold", V1_OUT);

        // Reset at cnt=7 discards the partial computation
        bus.state_in = V2_IN;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("pre_rst_row_index", 128'(row_index), 128'(3));
        rst = 1'b0;
        #2;
        check("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("mid_rst_state_out", bus.state_out, 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("post_rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("post_rst_state_out", bus.state_out, 128'(0));
        accept_and_wait("after_rst", V1_IN, V1_OUT);
        release_out("after_rst", V1_OUT);

        // Input noise and stray out_ready during CALC; row_index walk
        bus.state_in = V2_IN;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            check("calc_row_index", 128'(row_index), 128'(i % 4));
            bus.in_valid  = (i % 2 == 0);
            bus.state_in  = {4{$urandom()}};
            bus.out_ready = (i % 3 == 0);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("noise_out_valid", 128'(bus.out_valid), 128'(1));
        check("noise_result", bus.state_out, V2_OUT);
        check("done_row_index", 128'(row_index), 128'(0));
        release_out("noise", V2_OUT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
